// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Optional stall/flush performance counters are compiled in when ID_EX_PERF_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_we,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              exm_we,
  input  logic [4:0]        exm_wa,
  input  logic [DATA_W-1:0] exm_wd,
  input  logic              mwb_we,
  input  logic [4:0]        mwb_wa,
  input  logic [DATA_W-1:0] mwb_wd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_we,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              hz;
  logic              bubble;

  // r0 is hardwired, so a zero source register never takes a forwarded value.
  always_comb begin
    fwd_a = rf_data_a;
    if (id_rs != 5'd0) begin
      if (exm_we && exm_wa == id_rs)      fwd_a = exm_wd;
      else if (mwb_we && mwb_wa == id_rs) fwd_a = mwb_wd;
    end
  end

  always_comb begin
    fwd_b = rf_data_b;
    if (id_rt != 5'd0) begin
      if (exm_we && exm_wa == id_rt)      fwd_b = exm_wd;
      else if (mwb_we && mwb_wa == id_rt) fwd_b = mwb_wd;
    end
  end

  always_comb begin
    hz = id_valid && ex_valid && ex_mem_read && ex_reg_we && (ex_rd != 5'd0) &&
         ((ex_rd == id_rs) || (ex_rd == id_rt));
    // Reset masks stall so a pending load-use cycle is dropped rather than held.
    stall  = hz && !flush && !rst;
    bubble = flush || hz || !id_valid;
  end

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid    <= 1'b0;
      ex_op_a     <= '0;
      ex_op_b     <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_reg_we   <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_ctrl     <= '0;
    end else begin
      ex_valid    <= 1'b1;
      ex_op_a     <= fwd_a;
      ex_op_b     <= fwd_b;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_reg_we   <= id_reg_we;
      ex_mem_read <= id_mem_read;
      ex_ctrl     <= id_ctrl;
    end
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/immediate width.
REQ-002 SHALL have parameter CTRL_W, default 8: pass-through EX/MEM/WB control bundle width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports id_valid input 1; id_rs, id_rt, id_rd input 5 each: decoded ID instruction fields.
REQ-006 SHALL have ports id_imm input DATA_W; id_reg_we, id_mem_read input 1 each; id_ctrl input CTRL_W.
REQ-007 SHALL have ports rf_data_a, rf_data_b  input  DATA_W: combinational register-file read data for id_rs/id_rt.
REQ-008 SHALL have ports exm_we input 1, exm_wa input 5, exm_wd input DATA_W: EX/MEM forwarding source.
REQ-009 SHALL have ports mwb_we input 1, mwb_wa input 5, mwb_wd input DATA_W: MEM/WB forwarding source (same values drive the register-file write port).
REQ-010 SHALL have port flush  input  1  squash ID instruction (taken branch/jump).
REQ-011 SHALL have port stall  output  1  hold PC and IF/ID register this cycle.
REQ-012 SHALL have outputs ex_valid 1, ex_op_a/ex_op_b/ex_imm DATA_W, ex_rs/ex_rt/ex_rd 5, ex_reg_we 1, ex_mem_read 1, ex_ctrl CTRL_W: registered ID/EX contents.

Function
REQ-013 Operand A SHALL be selected combinationally: id_rs==0 -> rf_data_a; else exm_we && exm_wa==id_rs -> exm_wd; else mwb_we && mwb_wa==id_rs -> mwb_wd; else rf_data_a.
REQ-014 Operand B SHALL use the same priority with id_rt/rf_data_b; EX/MEM always wins over MEM/WB when both match.
REQ-015 MEM/WB forwarding SHALL cover same-cycle register-file write (file updates only at the posedge, so its read data is stale that cycle).
REQ-016 Load-use hazard SHALL be hz = id_valid && ex_valid && ex_mem_read && ex_reg_we && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt).
REQ-017 stall SHALL equal hz && !flush; combinational, no registered latency.
REQ-018 Each posedge, if rst: clear all state; else if flush or hz: load bubble; else load ID fields and forwarded operands (1-cycle latency).
REQ-019 Bubble SHALL set ex_valid, ex_reg_we, ex_mem_read, ex_ctrl, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt, ex_rd all to 0.
REQ-020 id_valid=0 with no flush/hz SHALL load a bubble identically.
REQ-021 flush SHALL take priority over hz; a flushed cycle never asserts stall.
REQ-022 A load-use stall SHALL last exactly one cycle; next cycle the bubbled EX stage clears hz and the dependent value arrives via EX/MEM forwarding.
REQ-023 No state SHALL change except at posedge clk; no combinational path from outputs back to inputs.

Reset
REQ-024 rst high at a posedge SHALL zero every register (REQ-019 values) regardless of flush, hz, id_valid.
REQ-025 While rst high, stall SHALL be 0 (ex_valid is 0 after first reset edge); asserting rst mid-stall SHALL discard the pending instruction.
REQ-026 Performance counters (if compiled) SHALL reset to 0.

Configuration
REQ-027 Macro ID_EX_PERF_EN defined SHALL add outputs perf_stall_cnt and perf_flush_cnt (32 bits each), incrementing once per cycle with stall=1 / flush=1 respectively, saturating at 32'hFFFFFFFF.
REQ-028 Without ID_EX_PERF_EN those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-029 Reset: rst=1 one edge with id_valid=1, id_reg_we=1 -> all ex_* outputs 0, stall=0.
REQ-030 Forward priority: id_rs=5, exm_we=1 exm_wa=5 exm_wd=0x11, mwb_we=1 mwb_wa=5 mwb_wd=0x22, rf_data_a=0x33 -> next cycle ex_op_a=0x11; with exm_we=0 -> 0x22; with id_rs=0 -> 0x33.
REQ-031 Load-use: EX holds lw ex_rd=8 ex_mem_read=1; ID id_rt=8 -> stall=1 one cycle, next ex_valid=0; following cycle stall=0 and ex_op_b=exm_wd.
REQ-032 Flush vs hazard: same as REQ-031 with flush=1 -> stall=0, ex_valid=0 next cycle.
REQ-033 r0 guard: ex_rd=0 with ex_mem_read=1 and id_rs=0 -> stall=0; exm_wa=0 exm_we=1 -> ex_op_a=rf_data_a.
REQ-034 With ID_EX_PERF_EN: 3 load-use stalls and 2 flushes -> perf_stall_cnt=3, perf_flush_cnt=2; rst -> both 0.
